dino_game_ctrl: RTL and testbench

Per-frame game sequencer for tt_um_not_a_dinosaur. It sits between the input pins, the renderer and the obstacle generator. It owns the game state machine, the dino jump physics, the BCD score and the scroll speed. All game state advances only on a one-cycle frame_tick from the VGA timing block; the renderer reads dino_y, speed and score, and returns a collision flag.

---
 rtl/dino_pkg.sv | 17 +
 rtl/dino_bcd_counter.sv | 42 ++++
 rtl/dino_game_ctrl.sv | 135 +++++++++++++
 tb/tb_dino_game_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and default constants for the dino game sequencer.
package dino_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam int DINO_JUMP_VEL   = 12;
  localparam int DINO_GRAVITY    = 1;
  localparam int DINO_SPEED_INIT = 2;
  localparam int DINO_SPEED_MAX  = 8;

endpackage

// File: rtl/dino_bcd_counter.sv
// Four-digit BCD incrementer with synchronous clear and 9999->0000 wrap.
// carry_hundreds flags an increment that rolls the lower two digits to 00.
module dino_bcd_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count,
  output logic        carry_hundreds
);

  logic [15:0] count_nxt;
  logic        carry;

  always_comb begin
    count_nxt = count;
    carry     = inc;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_nxt[4*i +: 4] = 4'd0;
        end else begin
          count_nxt[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign carry_hundreds = inc && (count[7:0] == 8'h99);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/dino_game_ctrl.sv
// Per-frame game sequencer: state machine, jump physics, BCD score and scroll speed.
// All game state advances on frame_tick; only the button path and obstacle_clr run every clock.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int Y_W        = 7,
  parameter int JUMP_VEL   = DINO_JUMP_VEL,
  parameter int GRAVITY    = DINO_GRAVITY,
  parameter int SCORE_DIV  = 6,
  parameter int SPEED_INIT = DINO_SPEED_INIT,
  parameter int SPEED_MAX  = DINO_SPEED_MAX,
  parameter int DEAD_HOLD  = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               jump_btn,
  input  logic               collision,
  output logic [STATE_W-1:0] state,
  output logic [Y_W-1:0]     dino_y,
  output logic [15:0]        score_bcd,
  output logic [3:0]         speed,
  output logic               scroll_en,
  output logic               obstacle_clr
);

  localparam int VW     = Y_W + 1;
  localparam int DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int HOLD_W = $clog2(DEAD_HOLD + 1);

  state_t                  st;
  logic                    sync1, sync2, sync_prev;
  logic                    pending;
  logic [DIV_W-1:0]        div_cnt;
  logic [HOLD_W-1:0]       hold_cnt;
  logic signed [VW-1:0]    vel;
  logic signed [VW-1:0]    y_sum;
  logic                    btn_edge, hold_done, grounded, div_wrap;
  logic                    start_run, go_dead, run_tick, jump_now, score_inc;
  logic                    carry_hundreds;

  assign btn_edge  = sync2 & ~sync_prev;
  assign hold_done = (hold_cnt == HOLD_W'(DEAD_HOLD));
  assign grounded  = (dino_y == '0);
  assign div_wrap  = (div_cnt == DIV_W'(SCORE_DIV - 1));

  // In DEAD, pending can only be set once hold is reached, so no extra gating here.
  assign start_run = frame_tick && pending && (st == ST_IDLE || st == ST_DEAD);
  assign go_dead   = frame_tick && (st == ST_RUN) && collision;
  assign run_tick  = frame_tick && (st == ST_RUN) && !collision;
  assign jump_now  = run_tick && grounded && pending;
  assign score_inc = run_tick && div_wrap;

  assign y_sum     = $signed({1'b0, dino_y}) + vel;
  assign state     = st;
  assign scroll_en = (st == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync_prev    <= 1'b0;
      pending      <= 1'b0;
      obstacle_clr <= 1'b0;
    end else begin
      sync1        <= jump_btn;
      sync2        <= sync1;
      sync_prev    <= sync2;
      obstacle_clr <= start_run;
      if (start_run || go_dead || jump_now) begin
        pending <= 1'b0;
      end else if (btn_edge && (st != ST_DEAD || hold_done)) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      dino_y   <= '0;
      vel      <= '0;
      speed    <= 4'(SPEED_INIT);
      div_cnt  <= '0;
      hold_cnt <= '0;
    end else if (start_run) begin
      st      <= ST_RUN;
      dino_y  <= '0;
      vel     <= '0;
      speed   <= 4'(SPEED_INIT);
      div_cnt <= '0;
    end else if (frame_tick) begin
      case (st)
        ST_RUN: begin
          if (collision) begin
            st       <= ST_DEAD;
            hold_cnt <= '0;
          end else begin
            if (grounded) begin
              if (pending) begin
                dino_y <= Y_W'(JUMP_VEL);
                vel    <= VW'(JUMP_VEL - GRAVITY);
              end
            end else if (y_sum[VW-1] || y_sum == '0) begin
              dino_y <= '0;
              vel    <= '0;
            end else begin
              dino_y <= y_sum[Y_W-1:0];
              vel    <= vel - VW'(GRAVITY);
            end
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (carry_hundreds && speed < 4'(SPEED_MAX)) begin
              speed <= speed + 4'd1;
            end
          end
        end
        ST_DEAD: begin
          if (!hold_done) hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        ST_IDLE: ;
        default: st <= ST_IDLE;
      endcase
    end
  end

  dino_bcd_counter u_score (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (start_run),
    .inc            (score_inc),
    .count          (score_bcd),
    .carry_hundreds (carry_hundreds)
  );

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed bench for dino_game_ctrl plus a standalone run of the BCD counter up to its wrap.
module tb_dino_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        jump_btn = 1'b0;
  logic        collision = 1'b0;
  logic [1:0]  state;
  logic [6:0]  dino_y;
  logic [15:0] score_bcd;
  logic [3:0]  speed;
  logic        scroll_en;
  logic        obstacle_clr;

  logic        bcd_clr = 1'b0;
  logic        bcd_inc = 1'b0;
  logic [15:0] bcd_count;
  logic        bcd_carry;

  int n_checks = 0;
  int n_fail = 0;
  int run_ticks = 0;
  int y_tab [25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                     78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

  always #5 clk = ~clk;

  dino_game_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .jump_btn     (jump_btn),
    .collision    (collision),
    .state        (state),
    .dino_y       (dino_y),
    .score_bcd    (score_bcd),
    .speed        (speed),
    .scroll_en    (scroll_en),
    .obstacle_clr (obstacle_clr)
  );

  dino_bcd_counter u_bcd (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (bcd_clr),
    .inc            (bcd_inc),
    .count          (bcd_count),
    .carry_hundreds (bcd_carry)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int w;
    w = v % 10000;
    return {4'(w / 1000), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
  endfunction

  function automatic int exp_speed(input int sc);
    int s;
    s = 2 + sc / 100;
    return (s > 8) ? 8 : s;
  endfunction

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic rtick();
    tick();
    run_ticks++;
  endtask

  task automatic press();
    @(negedge clk);
    jump_btn = 1'b1;
    repeat (4) @(negedge clk);
    jump_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_score(input string tag);
    chk({tag, "_score"}, 32'(score_bcd), 32'(to_bcd(run_ticks / 6)));
    chk({tag, "_speed"}, 32'(speed), 32'(exp_speed(run_ticks / 6)));
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_y", 32'(dino_y), 32'd0);
    chk("rst_score", 32'(score_bcd), 32'h0);
    chk("rst_speed", 32'(speed), 32'd2);
    chk("rst_scroll", 32'(scroll_en), 32'd0);
    chk("rst_oclr", 32'(obstacle_clr), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_scroll", 32'(scroll_en), 32'd0);
      chk("idle_score", 32'(score_bcd), 32'h0);
    end

    // Start from IDLE
    press();
    chk("pre_start_state", 32'(state), 32'd0);
    tick();
    chk("start_state", 32'(state), 32'd1);
    chk("start_scroll", 32'(scroll_en), 32'd1);
    chk("start_oclr", 32'(obstacle_clr), 32'd1);
    chk("start_score", 32'(score_bcd), 32'h0);
    @(negedge clk);
    chk("start_oclr_end", 32'(obstacle_clr), 32'd0);

    // Score divider
    repeat (5) rtick();
    chk("score5", 32'(score_bcd), 32'h0000);
    rtick();
    chk("score6", 32'(score_bcd), 32'h0001);

    // Full jump with a buffered second press mid-air
    press();
    for (int i = 0; i < 25; i++) begin
      rtick();
      chk("jump_y", 32'(dino_y), 32'(y_tab[i]));
      if (i == 9) press();
    end
    rtick();
    chk("relaunch_y", 32'(dino_y), 32'd12);
    for (int i = 1; i < 25; i++) begin
      rtick();
      chk("jump2_y", 32'(dino_y), 32'(y_tab[i]));
    end
    chk_score("after_jump");

    // Hundreds rollover and speed saturation
    while (run_ticks < 599) rtick();
    chk_score("s0099");
    rtick();
    chk_score("s0100");
    chk("speed3", 32'(speed), 32'd3);
    while (run_ticks < 3599) rtick();
    chk_score("s0599");
    rtick();
    chk("speed8", 32'(speed), 32'd8);
    while (run_ticks < 4200) rtick();
    chk_score("s0700");
    chk("speed_sat", 32'(speed), 32'd8);

    // Collision on the divider wrap tick while airborne
    press();
    repeat (5) rtick();
    chk("pre_coll_y", 32'(dino_y), 32'd50);
    collision = 1'b1;
    tick();
    collision = 1'b0;
    chk("coll_state", 32'(state), 32'd2);
    chk("coll_y", 32'(dino_y), 32'd50);
    chk("coll_score", 32'(score_bcd), 32'h0700);
    chk("coll_scroll", 32'(scroll_en), 32'd0);

    // DEAD hold: presses before the hold is reached are dropped
    repeat (10) tick();
    press();
    tick();
    chk("dead_early_press", 32'(state), 32'd2);
    repeat (18) tick();
    press();
    tick();
    chk("dead_hold29_press", 32'(state), 32'd2);
    chk("dead_y_frozen", 32'(dino_y), 32'd50);
    press();
    tick();
    run_ticks = 0;
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_score", 32'(score_bcd), 32'h0);
    chk("restart_speed", 32'(speed), 32'd2);
    chk("restart_y", 32'(dino_y), 32'd0);
    chk("restart_oclr", 32'(obstacle_clr), 32'd1);
    @(negedge clk);
    chk("restart_oclr_end", 32'(obstacle_clr), 32'd0);

    // Asynchronous reset mid-jump
    press();
    repeat (5) rtick();
    chk("mid_jump_y", 32'(dino_y), 32'd50);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_y", 32'(dino_y), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_speed", 32'(speed), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;

    // Standalone BCD counter run to the 9999 wrap
    @(negedge clk);
    bcd_inc = 1'b1;
    repeat (98) @(negedge clk);
    chk("bcd_0098", 32'(bcd_count), 32'h0098);
    chk("bcd_carry_0098", 32'(bcd_carry), 32'd0);
    @(negedge clk);
    chk("bcd_0099", 32'(bcd_count), 32'h0099);
    chk("bcd_carry_0099", 32'(bcd_carry), 32'd1);
    @(negedge clk);
    chk("bcd_0100", 32'(bcd_count), 32'h0100);
    repeat (9899) @(negedge clk);
    chk("bcd_9999", 32'(bcd_count), 32'h9999);
    chk("bcd_carry_9999", 32'(bcd_carry), 32'd1);
    @(negedge clk);
    chk("bcd_wrap", 32'(bcd_count), 32'h0000);
    repeat (3) @(negedge clk);
    bcd_clr = 1'b1;
    @(negedge clk);
    bcd_clr = 1'b0;
    bcd_inc = 1'b0;
    chk("bcd_clr", 32'(bcd_count), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
